// File: rtl/l2_req_arb_resp_route.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : l2_req_arb_resp_route
// Purpose  : Two-master to one-slave TCDM request arbiter for the L2 crossbar.
//            Round-robin selects one of two requests and forwards it to the
//            slave. Each accepted transaction's master ID is recorded in an
//            in-order ID FIFO. Each returning r_valid is steered back to the
//            master that issued the transaction.
// Ports    : clk_i, rst_i                  - clock, synchronous active-high reset
//            data_*0_i / data_*1_i         - master 0 / 1 request channels
//            data_gnt0_o / data_gnt1_o     - grants back to the masters
//            data_r_valid*_o, data_r_rdata*_o - routed responses
//            data_*_o / data_gnt_i         - slave request channel
//            data_r_valid_i, data_r_rdata_i - slave response channel
//            err_o                         - sticky "response with nothing outstanding"
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module l2_req_arb_resp_route #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // master 0
  input  logic                  data_req0_i,
  input  logic [ADDR_WIDTH-1:0] data_add0_i,
  input  logic                  data_wen0_i,
  input  logic [DATA_WIDTH-1:0] data_wdata0_i,
  input  logic [BE_WIDTH-1:0]   data_be0_i,
  output logic                  data_gnt0_o,
  output logic                  data_r_valid0_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata0_o,
  // master 1
  input  logic                  data_req1_i,
  input  logic [ADDR_WIDTH-1:0] data_add1_i,
  input  logic                  data_wen1_i,
  input  logic [DATA_WIDTH-1:0] data_wdata1_i,
  input  logic [BE_WIDTH-1:0]   data_be1_i,
  output logic                  data_gnt1_o,
  output logic                  data_r_valid1_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata1_o,
  // slave
  output logic                  data_req_o,
  output logic [ADDR_WIDTH-1:0] data_add_o,
  output logic                  data_wen_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  input  logic                  data_gnt_i,
  input  logic                  data_r_valid_i,
  input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
  // status
  output logic                  err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic             prio_q;
  logic             id_fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  logic not_empty;
  logic pop;
  logic can_accept;
  logic sel;
  logic accept;
  logic head;

  assign not_empty  = (count_q != '0);
  assign pop        = data_r_valid_i & not_empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign can_accept = (count_q < DEPTH_C) | pop;

  // Lone requester wins; on collision or idle the priority flag decides.
  always_comb begin
    sel = prio_q;
    if (data_req0_i && !data_req1_i) begin
      sel = 1'b0;
    end else if (data_req1_i && !data_req0_i) begin
      sel = 1'b1;
    end
  end

  assign data_req_o   = (data_req0_i | data_req1_i) & can_accept;
  assign data_add_o   = sel ? data_add1_i   : data_add0_i;
  assign data_wen_o   = sel ? data_wen1_i   : data_wen0_i;
  assign data_wdata_o = sel ? data_wdata1_i : data_wdata0_i;
  assign data_be_o    = sel ? data_be1_i    : data_be0_i;

  assign accept      = data_req_o & data_gnt_i;
  assign data_gnt0_o = accept & ~sel;
  assign data_gnt1_o = accept &  sel;

  // Response routing uses the oldest outstanding ID, never the one being pushed.
  assign head            = id_fifo_q[rd_ptr_q];
  assign data_r_valid0_o = pop & ~head;
  assign data_r_valid1_o = pop &  head;
  assign data_r_rdata0_o = data_r_rdata_i;
  assign data_r_rdata1_o = data_r_rdata_i;

  assign err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        id_fifo_q[i] <= 1'b0;
      end
    end else begin
      if (accept) begin
        id_fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
        prio_q              <= ~sel;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(accept) - CNT_W'(pop);
      if (data_r_valid_i && !not_empty) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
